protocol_mc_fsm: RTL and testbench

//  Multi-channel successor of the single-bit protocol FSM. Round-robin arbitrates NUM_CH

---
 rtl/protocol_mc_fsm_pkg.sv | 21 ++
 rtl/protocol_mc_fsm_rr_arbiter.sv | 32 +++
 rtl/protocol_mc_fsm.sv | 125 ++++++++++++
 tb/tb_protocol_mc_fsm.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/protocol_mc_fsm_pkg.sv
// Shared types and width helpers for the multi-channel protocol FSM.
package protocol_mc_fsm_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEND = 3'd1,
    WAIT = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_t;

  // Bits needed to index n items; a single item still gets one bit.
  function automatic int minWidth(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int cntWidth(input int maxVal);
    return minWidth(maxVal + 1);
  endfunction

endpackage

// File: rtl/protocol_mc_fsm_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping around.
module rr_arbiter
  import protocol_mc_fsm_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = minWidth(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  logic found;
  int   pos;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    pos   = 0;
    for (int i = 0; i < N; i++) begin
      pos = (int'(ptr_i) + i) % N;
      if (!found && req_i[pos]) begin
        found      = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/protocol_mc_fsm.sv
// Arbitrates NUM_CH request channels onto one valid/ready link, waits for ack with timeout/retry.
module protocol_mc_fsm
  import protocol_mc_fsm_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 16,
  parameter int MAX_RETRY   = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_CH-1:0]        ch_req_i,
  input  logic [NUM_CH*DATA_W-1:0] ch_data_i,
  output logic [NUM_CH-1:0]        ch_grant_o,
  output logic [NUM_CH-1:0]        ch_done_o,
  output logic [NUM_CH-1:0]        ch_err_o,
  output logic                     tx_valid_o,
  output logic [DATA_W-1:0]        tx_data_o,
  input  logic                     tx_ready_i,
  input  logic                     rx_ack_i,
  output logic                     busy_o,
  output logic [2:0]               state_o
);

  localparam int IW = minWidth(NUM_CH);
  localparam int TW = cntWidth(TIMEOUT_CYC);
  localparam int RW = cntWidth(MAX_RETRY);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_CH - 1);

  state_t              state_q, state_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [RW-1:0]       retry_q, retry_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [IW-1:0]       capIdx_q, capIdx_d;
  logic [DATA_W-1:0]   payload_q, payload_d;
  logic [NUM_CH-1:0]   grant_q, grant_d;
  logic [NUM_CH-1:0]   arbGnt;
  logic [IW-1:0]       arbIdx;
  logic [NUM_CH-1:0]   capSel;

  rr_arbiter #(.N(NUM_CH), .IW(IW)) uArb (
    .req_i (ch_req_i),
    .ptr_i (ptr_q),
    .gnt_o (arbGnt),
    .idx_o (arbIdx)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      retry_q   <= '0;
      ptr_q     <= '0;
      capIdx_q  <= '0;
      payload_q <= '0;
      grant_q   <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      retry_q   <= retry_d;
      ptr_q     <= ptr_d;
      capIdx_q  <= capIdx_d;
      payload_q <= payload_d;
      grant_q   <= grant_d;
    end
  end

  // An ack arriving on the final timeout cycle takes precedence over a retry.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    retry_d   = retry_q;
    ptr_d     = ptr_q;
    capIdx_d  = capIdx_q;
    payload_d = payload_q;
    grant_d   = '0;
    case (state_q)
      IDLE: begin
        if (|ch_req_i) begin
          state_d   = SEND;
          capIdx_d  = arbIdx;
          payload_d = ch_data_i[arbIdx*DATA_W +: DATA_W];
          grant_d   = arbGnt;
        end
      end
      SEND: begin
        if (tx_ready_i) begin
          state_d = WAIT;
          timer_d = '0;
        end
      end
      WAIT: begin
        timer_d = timer_q + TW'(1);
        if (rx_ack_i) begin
          state_d = DONE;
        end else if (timer_q == TIMER_LAST) begin
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + RW'(1);
            state_d = SEND;
          end else begin
            state_d = ERR;
          end
        end
      end
      DONE, ERR: begin
        state_d = IDLE;
        retry_d = '0;
        ptr_d   = (capIdx_q == IDX_LAST) ? '0 : capIdx_q + IW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  assign capSel     = NUM_CH'(1) << capIdx_q;
  assign ch_grant_o = grant_q;
  assign ch_done_o  = (state_q == DONE) ? capSel : '0;
  assign ch_err_o   = (state_q == ERR) ? capSel : '0;
  assign tx_valid_o = (state_q == SEND);
  assign tx_data_o  = (state_q == SEND) ? payload_q : '0;
  assign busy_o     = (state_q != IDLE);
  assign state_o    = state_q;

endmodule

// File: tb/tb_protocol_mc_fsm.sv
// Table-driven, scoreboard-checked bench for protocol_mc_fsm (4 ch, 8-bit, timeout 8, 2 retries).
module tb_protocol_mc_fsm;
  import protocol_mc_fsm_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  chReq;
  logic [31:0] chData;
  logic [3:0]  chGrant, chDone, chErr;
  logic        txValid, txReady, rxAck, busy;
  logic [7:0]  txData;
  logic [2:0]  stateOut;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    int          readyDelay;
    int          ackDelay;
    logic        noise;
    logic [3:0]  expGnt;
    logic [7:0]  expData;
    logic        expErr;
    int          expPhases;
    int          expValid;
    int          expWait;
  } vec_t;

  typedef struct {
    int         kind;
    logic [3:0] ch;
    logic [7:0] data;
  } evt_t;

  evt_t expQ[$];
  vec_t vecs[13];
  vec_t postRst;

  protocol_mc_fsm #(
    .NUM_CH(4), .DATA_W(8), .TIMEOUT_CYC(8), .MAX_RETRY(2)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .ch_req_i   (chReq),
    .ch_data_i  (chData),
    .ch_grant_o (chGrant),
    .ch_done_o  (chDone),
    .ch_err_o   (chErr),
    .tx_valid_o (txValid),
    .tx_data_o  (txData),
    .tx_ready_i (txReady),
    .rx_ack_i   (rxAck),
    .busy_o     (busy),
    .state_o    (stateOut)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Each grant/done/err pulse must match the next expected event, in order.
  task automatic popCompare(input int kind, input logic [3:0] ch);
    evt_t e;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL sb unexpected: got kind %0d chan %b, expected no event", kind, ch);
    end else begin
      e = expQ.pop_front();
      checkOutput("sb kind", kind, e.kind);
      checkOutput("sb chan", {28'd0, ch}, {28'd0, e.ch});
      if (kind == 0) checkOutput("sb data", {24'd0, txData}, {24'd0, e.data});
    end
  endtask

  always @(negedge clk) begin
    if (chGrant != 4'd0) popCompare(0, chGrant);
    if (chDone != 4'd0) popCompare(1, chDone);
    if (chErr != 4'd0) popCompare(2, chErr);
  end

  // Runs one full transfer from IDLE; entered and left on a negedge with the DUT idle.
  task automatic applyStimulus(input vec_t v);
    int phases = 0;
    int validCyc = 0;
    int waitCyc = 0;
    int sendCyc = 0;
    int waitPhase = 0;
    int ackCyc = -1;
    int doneCyc = -1;
    bit finished = 1'b0;
    bit sawErr = 1'b0;
    expQ.push_back('{0, v.expGnt, v.expData});
    expQ.push_back('{v.expErr ? 2 : 1, v.expGnt, 8'h00});
    chReq = v.req;
    chData = v.data;
    rxAck = v.noise;
    txReady = 1'b0;
    @(negedge clk);
    checkOutput("grant latency", {28'd0, chGrant}, {28'd0, v.expGnt});
    checkOutput("tx_valid latency", {31'd0, txValid}, 32'd1);
    for (int c = 0; c < 300 && !finished; c++) begin
      rxAck = v.noise;
      txReady = 1'b0;
      if ((chDone | chErr) != 4'd0) begin
        finished = 1'b1;
        sawErr = |chErr;
        doneCyc = cyc;
      end else if (stateOut == SEND) begin
        if (sendCyc == 0) phases++;
        sendCyc++;
        validCyc++;
        checkOutput("tx_data stable", {24'd0, txData}, {24'd0, v.expData});
        txReady = (sendCyc > v.readyDelay);
        waitPhase = 0;
      end else if (stateOut == WAIT) begin
        sendCyc = 0;
        waitPhase++;
        waitCyc++;
        rxAck = (waitPhase == v.ackDelay);
        if (rxAck) ackCyc = cyc;
      end
      if (!finished) @(negedge clk);
    end
    if (!finished) begin
      checks++;
      errors++;
      $display("[TB] FAIL xfer timeout: got no done/err in 300 cycles, expected one");
    end
    chReq = 4'd0;
    rxAck = 1'b0;
    txReady = 1'b0;
    checkOutput("outcome err", {31'd0, sawErr}, {31'd0, v.expErr});
    checkOutput("send phases", phases, v.expPhases);
    checkOutput("valid cycles", validCyc, v.expValid);
    checkOutput("wait cycles", waitCyc, v.expWait);
    if (!v.expErr) checkOutput("done latency", doneCyc - ackCyc, 32'd1);
    @(negedge clk);
    checkOutput("idle busy", {31'd0, busy}, 32'd0);
    checkOutput("idle outputs", {19'd0, chGrant, chDone, chErr, txValid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    chReq = 4'd0;
    chData = 32'd0;
    txReady = 1'b0;
    rxAck = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset state", {29'd0, stateOut}, {29'd0, IDLE});
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset outputs", {11'd0, chGrant, chDone, chErr, txValid, txData}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    //           req      data          rdy ack nz  gnt      data   err ph val wait
    vecs[0]  = '{4'b1111, 32'hD4C3B2A1, 0, 1, 1'b0, 4'b0001, 8'hA1, 1'b0, 1, 1, 1};
    vecs[1]  = '{4'b1111, 32'hD4C3B2A1, 0, 2, 1'b0, 4'b0010, 8'hB2, 1'b0, 1, 1, 2};
    vecs[2]  = '{4'b1111, 32'hD4C3B2A1, 1, 1, 1'b0, 4'b0100, 8'hC3, 1'b0, 1, 2, 1};
    vecs[3]  = '{4'b1111, 32'hD4C3B2A1, 0, 4, 1'b0, 4'b1000, 8'hD4, 1'b0, 1, 1, 4};
    vecs[4]  = '{4'b1111, 32'hD4C3B2A1, 0, 1, 1'b0, 4'b0001, 8'hA1, 1'b0, 1, 1, 1};
    vecs[5]  = '{4'b0001, 32'h000000A5, 0, 3, 1'b0, 4'b0001, 8'hA5, 1'b0, 1, 1, 3};
    vecs[6]  = '{4'b0001, 32'h0000003C, 5, 2, 1'b0, 4'b0001, 8'h3C, 1'b0, 1, 6, 2};
    vecs[7]  = '{4'b0001, 32'h0000005A, 0, 0, 1'b0, 4'b0001, 8'h5A, 1'b1, 3, 3, 24};
    vecs[8]  = '{4'b0001, 32'h000000C7, 0, 8, 1'b1, 4'b0001, 8'hC7, 1'b0, 1, 1, 8};
    vecs[9]  = '{4'b0101, 32'h11223344, 0, 2, 1'b0, 4'b0100, 8'h22, 1'b0, 1, 1, 2};
    vecs[10] = '{4'b0011, 32'h55667788, 0, 1, 1'b0, 4'b0001, 8'h88, 1'b0, 1, 1, 1};
    vecs[11] = '{4'b1000, 32'h9A000000, 2, 0, 1'b1, 4'b1000, 8'h9A, 1'b1, 3, 9, 24};
    vecs[12] = '{4'b0010, 32'h0000EF00, 0, 5, 1'b0, 4'b0010, 8'hEF, 1'b0, 1, 1, 5};

    for (int i = 0; i < 13; i++) applyStimulus(vecs[i]);

    // Reset in the middle of WAIT must drop the transfer and restore ch0 priority.
    expQ.push_back('{0, 4'b0100, 8'hBB});
    chReq = 4'b0100;
    chData = 32'h00BB0000;
    txReady = 1'b1;
    @(negedge clk);
    chReq = 4'd0;
    for (int c = 0; c < 20 && stateOut != WAIT; c++) @(negedge clk);
    checkOutput("reach WAIT", {29'd0, stateOut}, {29'd0, WAIT});
    txReady = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    rxAck = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checkOutput("rst state", {29'd0, stateOut}, {29'd0, IDLE});
      checkOutput("rst outputs", {10'd0, busy, chGrant, chDone, chErr, txValid, txData}, 32'd0);
    end
    rst = 1'b0;
    rxAck = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst no pending", expQ.size(), 32'd0);
    postRst = '{4'b1001, 32'h77000066, 0, 2, 1'b0, 4'b0001, 8'h66, 1'b0, 1, 1, 2};
    applyStimulus(postRst);

    repeat (2) @(negedge clk);
    checkOutput("sb drained", expQ.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
